// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the RS(255,239) syndrome stage.
// Field: primitive polynomial 0x11D, alpha = 0x02.
package rs_pkg;

  localparam int SYM_W = 8;
  localparam int N     = 255;
  localparam int K     = 239;
  localparam int NSYND = 16;

  // Low byte of the primitive polynomial; the x^8 term is implied by the shift-out
  localparam logic [SYM_W-1:0] GF_POLY = 8'h1D;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // alpha^j for j = 0..15, one per syndrome
  localparam sym_t ALPHA_POW [0:15] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26
  };

  // General GF(2^8) product; used only to build constant XOR matrices at elaboration
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t prod;
    sym_t x;
    prod = '0;
    x    = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) prod ^= x;
      x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ GF_POLY) : {x[SYM_W-2:0], 1'b0};
    end
    return prod;
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Constant multiplier by alpha^EXP in GF(2^8), EXP in 0..15.
// Pure XOR network: every column is a compile-time constant.
module gf_const_mul
  import rs_pkg::*;
#(
  parameter int EXP = 0
) (
  input  logic [SYM_W-1:0] a,
  output logic [SYM_W-1:0] p
);

  localparam sym_t COEF = ALPHA_POW[EXP];

  // Column i of the matrix is alpha^EXP * x^i
  function automatic sym_t column(input int i);
    return gf_mul(COEF, sym_t'(1) << i);
  endfunction

  // Each set input bit folds its constant column into the product
  always_comb begin
    p = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (a[i]) p ^= column(i);
    end
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator: S_j = r(alpha^j), j = 0..NSYND-1, Horner form.
// Optional erroneous-frame counter enabled by defining RS_SYND_ERRCNT_EN.
module rs_syndrome_calc #(
  parameter int N     = rs_pkg::N,
  parameter int NSYND = rs_pkg::NSYND
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_sop,
  input  logic                            in_eop,
  input  logic [rs_pkg::SYM_W-1:0]        in_data,
  output logic [NSYND*rs_pkg::SYM_W-1:0]  synd_out,
  output logic                            synd_valid,
  output logic                            err_flag,
  output logic                            len_err,
  output logic                            frame_abort,
  output logic [15:0]                     err_cnt
);

  localparam int SYM_W = rs_pkg::SYM_W;
  localparam logic [7:0] N_SYM   = 8'(N);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef rs_pkg::sym_t   sym_t;
  typedef rs_pkg::state_t state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

  state_t state;
  state_t state_nx;
  logic   start;
  logic   step;
  logic   done;
  logic   abort;

  sym_t acc     [NSYND];
  sym_t acc_mul [NSYND];
  sym_t acc_nx  [NSYND];
  logic [NSYND*SYM_W-1:0] synd_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       ovf;
  logic       ovf_nx;
  logic       len_err_nx;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= rs_pkg::IDLE;
    else      state <= state_nx;
  end

  // Frame control: sop (re)starts, eop closes, sop inside a frame aborts it
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    step     = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    case (state)
      rs_pkg::IDLE: begin
        if (in_valid && in_sop) begin
          start = 1'b1;
          if (in_eop) done = 1'b1;
          else        state_nx = rs_pkg::ACC;
        end
      end
      rs_pkg::ACC: begin
        if (in_valid) begin
          if (in_sop) begin
            start = 1'b1;
            abort = 1'b1;
          end else begin
            step = 1'b1;
          end
          if (in_eop) begin
            done     = 1'b1;
            state_nx = rs_pkg::IDLE;
          end
        end
      end
      default: state_nx = rs_pkg::IDLE;
    endcase
  end

  for (genvar j = 0; j < NSYND; j++) begin : g_mul
    gf_const_mul #(.EXP(j)) u_mul (
      .a(acc[j]),
      .p(acc_mul[j])
    );
  end

  // Horner step for every syndrome, plus the flattened result including this beat
  always_comb begin
    synd_nx = '0;
    for (int j = 0; j < NSYND; j++) begin
      acc_nx[j] = start ? in_data : (acc_mul[j] ^ in_data);
      synd_nx[j*SYM_W +: SYM_W] = acc_nx[j];
    end
    cnt_nx     = start ? 8'd1 : sat_inc8(cnt);
    // ovf remembers a beat arriving after the counter already sat at its ceiling
    ovf_nx     = start ? 1'b0 : (ovf | (cnt == CNT_MAX));
    len_err_nx = ovf_nx | (cnt_nx != N_SYM);
  end

  // Accumulators and symbol counter advance only on accepted beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NSYND; j++) acc[j] <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (start || step) begin
      for (int j = 0; j < NSYND; j++) acc[j] <= acc_nx[j];
      cnt <= cnt_nx;
      ovf <= ovf_nx;
    end
  end

  // Result register: latched on the closing beat, held until the next frame closes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      synd_out    <= '0;
      synd_valid  <= 1'b0;
      err_flag    <= 1'b0;
      len_err     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      synd_valid  <= done;
      frame_abort <= abort;
      if (done) begin
        synd_out <= synd_nx;
        err_flag <= |synd_nx;
        len_err  <= len_err_nx;
      end
    end
  end

`ifdef RS_SYND_ERRCNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counts reported frames that carry a syndrome error or a length error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     err_cnt <= '0;
    else if (synd_valid && (err_flag || len_err)) err_cnt <= sat_inc16(err_cnt);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Syndrome stage of the RS(255,239) decoder, GF(2^8), primitive polynomial 0x11D, alpha = 0x02, first consecutive root alpha^0.
- Consumes the received symbol stream, one symbol per accepted beat.
- Evaluates S_j = r(alpha^j) for j = 0..NSYND-1 with Horner recurrences, one constant-multiplier per syndrome.
- Hands the flat syndrome vector plus status to the key-equation stage.

Parameters:
- N, 255, codeword length in symbols.
- NSYND, 16, number of syndromes (2t).
- SYM_W, 8, symbol width (fixed at 8; not user-overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  symbol beat valid; gaps allowed, no backpressure.
- in_sop  in  1  first symbol of frame (position N-1); qualified by in_valid.
- in_eop  in  1  last symbol of frame (position 0); qualified by in_valid.
- in_data  in  8  received symbol.
- synd_out  out  NSYND*8  S_j in bits [8j+7:8j].
- synd_valid  out  1  one-cycle pulse: synd_out/err_flag/len_err updated.
- err_flag  out  1  1 if any S_j != 0 for the completed frame.
- len_err  out  1  1 if the completed frame length != N.
- frame_abort  out  1  one-cycle pulse: in_sop arrived mid-frame.
- err_cnt  out  16  erroneous-frame count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all accumulators, synd_out, synd_valid, err_flag, len_err, frame_abort, err_cnt = 0; state IDLE; symbol counter = 0.
- States:
  - IDLE: waits for in_valid & in_sop.
  - ACC: accumulating.
- Accumulation on each in_valid beat:
  - sop beat: acc_j <= in_data for all j; cnt <= 1.
  - Other beat in ACC: acc_j <= gfmul(acc_j, alpha^j) ^ in_data; cnt <= cnt+1, saturating at 255.
  - in_valid=0: hold everything.
- Beat with in_valid & in_eop in ACC, or sop&eop in the same beat:
  - Next cycle: synd_out <= final acc values including this beat; synd_valid = 1 for one cycle.
  - err_flag <= OR-reduce of the final values.
  - len_err <= (final count != N).
  - State -> IDLE.
- Latency: synd_valid one cycle after the eop beat.
- synd_out/err_flag/len_err hold until the next synd_valid.
- Symbol after eop without sop (in IDLE): ignored, no state change.
- sop while in ACC: frame_abort pulses next cycle; the partial frame is discarded (no synd_valid); the new frame starts from this beat.
- More than N beats without eop: counter saturates, accumulation continues; len_err=1 at eop.
- alpha^0 multiply is identity: S_0 is the XOR of all symbols.
- Reset mid-frame: frame lost, no synd_valid, outputs cleared.

Optional Feature:
- Macro RS_SYND_ERRCNT_EN.
- Defined: err_cnt increments by 1 on each synd_valid with err_flag=1 or len_err=1, saturating at 0xFFFF; cleared only by reset.
- Undefined: counter logic absent, err_cnt tied to 0.

Decomposition:
- Shared package rs_pkg holds:
  - GF_POLY = 8'h1D, SYM_W = 8, N = 255, K = 239, NSYND = 16.
  - Constant table ALPHA_POW[0..15].
  - Symbol typedef.
  - State enum {IDLE, ACC}.
- Sub-module gf_const_mul (parameter EXP): combinational 8-bit multiply by alpha^EXP as an XOR matrix; NSYND instances via generate.

Test Plan:
- 255 zero symbols, sop on first, eop on last -> synd_valid 1 cycle after eop; synd_out=0, err_flag=0, len_err=0.
- Same frame but last symbol 0x01 -> every S_j=0x01, err_flag=1.
- Same frame but first symbol 0x01, rest 0 -> S_0=0x01, S_1=0x8E (alpha^254), err_flag=1.
- Previous frame with in_valid gapped 1-of-3 cycles -> identical synd_out; synd_valid exactly once.
- eop on beat 100 -> synd_valid, len_err=1. Then sop at beat 50 of a new frame -> frame_abort pulse, no synd_valid, following full 255-beat zero frame gives synd_out=0.
- rst low mid-frame, then a clean zero frame -> all outputs 0 during reset; one correct synd_valid afterward. With RS_SYND_ERRCNT_EN, three errored frames -> err_cnt=3.
